// File: rtl/run_det_pkg.sv
// Shared encodings for the run-length detector: configuration modes, FSM
// states and the polarity qualification helper used by the detector core.
package run_det_pkg;

  typedef enum logic [1:0] {
    MODE_EITHER = 2'b00,
    MODE_ONES   = 2'b01,
    MODE_ZEROS  = 2'b10,
    MODE_OFF    = 2'b11
  } mode_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // True when a run of polarity b may raise a detection under mode m.
  function automatic logic polarity_ok(input mode_t m, input logic b);
    logic ok;
    case (m)
      MODE_EITHER: ok = 1'b1;
      MODE_ONES:   ok = b;
      MODE_ZEROS:  ok = ~b;
      default:     ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/run_length_detector_if.sv
// Bundle of the detector's configuration, stream and status signals.
// master drives the stream and configuration; slave is the detector.
interface run_length_detector_if #(
  parameter int RL_W  = 4,
  parameter int CNT_W = 16
);

  logic             en;
  logic             inp;
  logic             clr;
  logic [RL_W-1:0]  run_len;
  logic [1:0]       mode;
  logic             overlap;
  logic             outp;
  logic             outp_bit;
  logic [CNT_W-1:0] det_count;
  logic             sat;

  modport master (
    output en, inp, clr, run_len, mode, overlap,
    input  outp, outp_bit, det_count, sat
  );

  modport slave (
    input  en, inp, clr, run_len, mode, overlap,
    output outp, outp_bit, det_count, sat
  );

endinterface

// File: rtl/sat_counter.sv
// Parametrised-width up counter that sticks at all-ones. sat is sticky and
// rises on the increment that lands the count on all-ones; clr clears both.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count,
  output logic         sat
);

  localparam logic [W-1:0] TOP = '1;

  // Count qualified increments until the all-ones ceiling is reached.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      sat   <= 1'b0;
    end else if (clr) begin
      count <= '0;
      sat   <= 1'b0;
    end else if (inc && (count != TOP)) begin
      count <= count + W'(1);
      if (count == (TOP - W'(1))) begin
        sat <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/run_length_detector.sv
// Serial-bit run detector: flags run_len consecutive equal bits on a
// qualified 1-bit stream, with polarity selection, overlapping or restarting
// detection, and a saturating detection counter.
module run_length_detector
  import run_det_pkg::*;
#(
  parameter int MAX_RUN = 8,
  parameter int RL_W    = 4,
  parameter int CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  run_length_detector_if.slave bus
);

  localparam logic [RL_W-1:0] MAX_LEN = RL_W'(MAX_RUN);
  localparam logic [RL_W-1:0] MIN_LEN = RL_W'(2);

  // Bring the requested run length into the supported 2..MAX_RUN window.
  function automatic logic [RL_W-1:0] clamp_len(input logic [RL_W-1:0] req);
    logic [RL_W-1:0] len;
    if (req < MIN_LEN) begin
      len = MIN_LEN;
    end else if (req > MAX_LEN) begin
      len = MAX_LEN;
    end else begin
      len = req;
    end
    return len;
  endfunction

  // Extend the run length by one, holding at MAX_RUN on very long runs.
  function automatic logic [RL_W-1:0] sat_incr(input logic [RL_W-1:0] cnt);
    logic [RL_W-1:0] nxt;
    if (cnt >= MAX_LEN) begin
      nxt = MAX_LEN;
    end else begin
      nxt = cnt + RL_W'(1);
    end
    return nxt;
  endfunction

  state_t          state;
  state_t          state_nxt;
  logic [RL_W-1:0] run_cnt;
  logic [RL_W-1:0] run_cnt_nxt;
  logic [RL_W-1:0] run_len_eff;
  logic [RL_W-1:0] run_ext;
  logic            last_bit;
  logic            last_bit_nxt;
  logic            hit;

  // Next-state and hit decode: clr wins over en, en=0 freezes the run.
  always_comb begin
    state_nxt    = state;
    run_cnt_nxt  = run_cnt;
    last_bit_nxt = last_bit;
    hit          = 1'b0;
    run_len_eff  = clamp_len(bus.run_len);
    run_ext      = sat_incr(run_cnt);

    if (bus.clr) begin
      state_nxt   = ST_IDLE;
      run_cnt_nxt = '0;
    end else if (bus.en) begin
      if (state == ST_IDLE) begin
        state_nxt    = ST_RUN;
        run_cnt_nxt  = RL_W'(1);
        last_bit_nxt = bus.inp;
      end else if (bus.inp != last_bit) begin
        run_cnt_nxt  = RL_W'(1);
        last_bit_nxt = bus.inp;
      end else begin
        // A run in a disallowed polarity keeps counting but never hits.
        hit = (run_ext >= run_len_eff) &&
              polarity_ok(mode_t'(bus.mode), bus.inp);
        if (hit && !bus.overlap) begin
          state_nxt   = ST_IDLE;
          run_cnt_nxt = '0;
        end else begin
          run_cnt_nxt = run_ext;
        end
      end
    end
  end

  // Run-tracking state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      run_cnt  <= '0;
      last_bit <= 1'b0;
    end else begin
      state    <= state_nxt;
      run_cnt  <= run_cnt_nxt;
      last_bit <= last_bit_nxt;
    end
  end

  // One-cycle detection pulse and the polarity of the run that caused it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.outp     <= 1'b0;
      bus.outp_bit <= 1'b0;
    end else begin
      bus.outp <= hit;
      if (hit) begin
        bus.outp_bit <= bus.inp;
      end
    end
  end

  sat_counter #(
    .W (CNT_W)
  ) u_det_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (bus.clr),
    .inc   (hit),
    .count (bus.det_count),
    .sat   (bus.sat)
  );

endmodule

// File: tb/tb_run_length_detector.sv
// Directed bench for run_length_detector: a default-width instance for the
// detection behaviour and a 3-bit-counter instance for saturation.
module tb_run_length_detector;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  run_length_detector_if #(.RL_W(4), .CNT_W(16)) bus ();
  run_length_detector_if #(.RL_W(4), .CNT_W(3))  bus2 ();

  run_length_detector #(.MAX_RUN(8), .RL_W(4), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  run_length_detector #(.MAX_RUN(8), .RL_W(4), .CNT_W(3)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input logic b, input logic e);
    bus.inp = b;
    bus.en  = e;
    @(posedge clk);
    #1;
  endtask

  task automatic step2(input logic b, input logic e);
    bus2.inp = b;
    bus2.en  = e;
    @(posedge clk);
    #1;
  endtask

  task automatic do_clr();
    bus.clr = 1'b1;
    bus.en  = 1'b0;
    @(posedge clk);
    #1;
    bus.clr = 1'b0;
  endtask

  task automatic config_set(input logic [3:0] len, input logic [1:0] m, input logic ov);
    bus.run_len = len;
    bus.mode    = m;
    bus.overlap = ov;
  endtask

  // bits[i] is the i-th sampled bit; pulses[i] is outp expected right after it.
  task automatic run_stream(input string tag, input int n,
                            input logic [31:0] bits, input logic [31:0] pulses);
    for (int i = 0; i < n; i++) begin
      step(bits[i], 1'b1);
      check($sformatf("%s_outp%0d", tag, i), {31'b0, bus.outp}, {31'b0, pulses[i]});
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.en = 1'b0;  bus.inp = 1'b0;  bus.clr = 1'b0;
    config_set(4'd2, 2'b00, 1'b0);
    bus2.en = 1'b0; bus2.inp = 1'b0; bus2.clr = 1'b0;
    bus2.run_len = 4'd0; bus2.mode = 2'b00; bus2.overlap = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_outp", {31'b0, bus.outp}, 0);
    check("rst_outp_bit", {31'b0, bus.outp_bit}, 0);
    check("rst_count", {16'b0, bus.det_count}, 0);
    check("rst_sat", {31'b0, bus.sat}, 0);
    rst = 1'b0;
    #1;

    // Baseline: stream 0,1,0,0,1,1,1,0,1,1,1,0,1,0,1,0 with L=2.
    config_set(4'd2, 2'b00, 1'b0);
    run_stream("base", 16, 32'h5772, 32'h0228);
    check("base_count", {16'b0, bus.det_count}, 3);
    check("base_outp_bit", {31'b0, bus.outp_bit}, 1);
    do_clr();
    check("clr_count", {16'b0, bus.det_count}, 0);
    check("clr_outp_bit_held", {31'b0, bus.outp_bit}, 1);

    config_set(4'd2, 2'b00, 1'b1);
    run_stream("ovl", 16, 32'h5772, 32'h0668);
    check("ovl_count", {16'b0, bus.det_count}, 5);
    do_clr();

    // Length 4, ones only, seven ones.
    config_set(4'd4, 2'b01, 1'b0);
    run_stream("len4", 7, 32'h7F, 32'h08);
    check("len4_count", {16'b0, bus.det_count}, 1);
    do_clr();
    config_set(4'd4, 2'b01, 1'b1);
    run_stream("len4ov", 7, 32'h7F, 32'h78);
    check("len4ov_count", {16'b0, bus.det_count}, 4);
    do_clr();
    config_set(4'd4, 2'b10, 1'b1);
    run_stream("zeros", 7, 32'h7F, 32'h00);
    check("zeros_count", {16'b0, bus.det_count}, 0);
    do_clr();

    // run_len above MAX_RUN clamps to 8.
    config_set(4'd15, 2'b00, 1'b0);
    run_stream("clamp_hi", 8, 32'hFF, 32'h80);
    check("clamp_hi_count", {16'b0, bus.det_count}, 1);
    do_clr();

    // Detection disabled.
    config_set(4'd2, 2'b11, 1'b1);
    run_stream("off", 4, 32'h0F, 32'h00);
    check("off_count", {16'b0, bus.det_count}, 0);
    do_clr();

    // Qualifier gap: en=0 bits are ignored and the pulse never stretches.
    config_set(4'd3, 2'b00, 1'b0);
    step(1'b1, 1'b1);
    check("qual_a", {31'b0, bus.outp}, 0);
    step(1'b1, 1'b1);
    check("qual_b", {31'b0, bus.outp}, 0);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0);
      check($sformatf("qual_gap%0d", i), {31'b0, bus.outp}, 0);
    end
    step(1'b1, 1'b1);
    check("qual_hit", {31'b0, bus.outp}, 1);
    step(1'b1, 1'b0);
    check("qual_no_stretch", {31'b0, bus.outp}, 0);
    check("qual_count", {16'b0, bus.det_count}, 1);

    // Reset mid-run, asserted between clock edges.
    config_set(4'd4, 2'b00, 1'b0);
    run_stream("pre_rst", 3, 32'h7, 32'h0);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_count", {16'b0, bus.det_count}, 0);
    check("mid_rst_outp_bit", {31'b0, bus.outp_bit}, 0);
    check("mid_rst_outp", {31'b0, bus.outp}, 0);
    #1;
    rst = 1'b0;
    run_stream("post_rst", 4, 32'hF, 32'h8);
    check("post_rst_count", {16'b0, bus.det_count}, 1);

    // Saturation on the 3-bit counter: L clamps to 2, ten ones give 9 hits.
    for (int i = 1; i <= 10; i++) begin
      step2(1'b1, 1'b1);
      check($sformatf("sat_outp%0d", i), {31'b0, bus2.outp}, (i >= 2) ? 1 : 0);
      check($sformatf("sat_count%0d", i), {29'b0, bus2.det_count},
            ((i - 1) > 7) ? 7 : (i - 1));
      check($sformatf("sat_flag%0d", i), {31'b0, bus2.sat}, ((i - 1) >= 7) ? 1 : 0);
    end
    bus2.clr = 1'b1;
    step2(1'b1, 1'b1);
    bus2.clr = 1'b0;
    check("sat_clr_count", {29'b0, bus2.det_count}, 0);
    check("sat_clr_flag", {31'b0, bus2.sat}, 0);
    check("sat_clr_outp", {31'b0, bus2.outp}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
